// File: rtl/pkt_extract.sv
// Receives five-word packets, holds their fields, screens them and hands valid ones
// to the Q-table update stage with a one-cycle start pulse and a completion watchdog.
module pkt_extract #(
   parameter int WORD_WIDTH = 16,
   parameter int WD_LIMIT   = 255
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_sop,
   output logic                  rx_ready,
   output logic [2:0]            fPacketType,
   output logic [WORD_WIDTH-1:0] fSourceID,
   output logic [WORD_WIDTH-1:0] fClusterID,
   output logic [WORD_WIDTH-1:0] fEnergyLeft,
   output logic [WORD_WIDTH-1:0] fQValue,
   output logic                  en,
   input  logic                  upd_done,
   output logic                  busy,
   output logic [7:0]            drop_count
);

   localparam int WD_W = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE, S_SRC, S_CLU, S_ENE, S_QV, S_CHECK, S_ISSUE, S_WAIT
   } state_t;

   state_t                state_q;
   logic [2:0]            type_q;
   logic [WORD_WIDTH-1:0] src_q, clu_q, ene_q, qv_q;
   logic [7:0]            drop_q;
   logic [7:0]            drop_d;
   logic [WD_W-1:0]       wd_q;
   logic                  upd_q;
   logic                  en_q;
   logic                  accept;
   logic                  pkt_bad;
   logic                  upd_rise;

   assign rx_ready = (state_q == S_IDLE) || (state_q == S_SRC) || (state_q == S_CLU) ||
                     (state_q == S_ENE)  || (state_q == S_QV);
   assign busy     = (state_q != S_IDLE);
   assign accept   = rx_valid && rx_ready;
   assign drop_d   = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
   assign pkt_bad  = (type_q == 3'd0) || (type_q > 3'd4) ||
                     (src_q == myNodeID) || (src_q == '1);
   // A level already high when S_WAIT is entered is stale; only a fresh edge completes.
   assign upd_rise = upd_done && !upd_q;

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         type_q  <= '0;
         src_q   <= '0;
         clu_q   <= '0;
         ene_q   <= '0;
         qv_q    <= '0;
         drop_q  <= '0;
         wd_q    <= '0;
         upd_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         upd_q <= upd_done;
         en_q  <= 1'b0;
         if (accept && rx_sop) begin
            // A header mid-packet aborts the partial packet and starts a new one.
            type_q  <= rx_data[WORD_WIDTH-1 -: 3];
            state_q <= S_SRC;
            if (state_q != S_IDLE) drop_q <= drop_d;
         end else begin
            case (state_q)
               S_IDLE: ;
               S_SRC: if (accept) begin src_q <= rx_data; state_q <= S_CLU; end
               S_CLU: if (accept) begin clu_q <= rx_data; state_q <= S_ENE; end
               S_ENE: if (accept) begin ene_q <= rx_data; state_q <= S_QV;  end
               S_QV:  if (accept) begin qv_q  <= rx_data; state_q <= S_CHECK; end
               S_CHECK: begin
                  if (pkt_bad) begin
                     drop_q  <= drop_d;
                     state_q <= S_IDLE;
                  end else begin
                     en_q    <= 1'b1;
                     state_q <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  wd_q    <= '0;
                  state_q <= S_WAIT;
               end
               S_WAIT: begin
                  if (upd_rise) begin
                     state_q <= S_IDLE;
                  end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                     drop_q  <= drop_d;
                     state_q <= S_IDLE;
                  end else begin
                     wd_q <= wd_q + 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign en          = en_q;
   assign fPacketType = type_q;
   assign fSourceID   = src_q;
   assign fClusterID  = clu_q;
   assign fEnergyLeft = ene_q;
   assign fQValue     = qv_q;
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_pkt_extract.sv
// Directed bench for pkt_extract: inputs change on the falling edge, outputs are
// checked on the falling edge (or mid-cycle for the asynchronous reset).
module tb_pkt_extract;

   logic        clock = 1'b0;
   logic        nrst = 1'b1;
   logic [15:0] myNodeID = 16'd1;
   logic [15:0] rx_data = 16'h0;
   logic        rx_valid = 1'b0;
   logic        rx_sop = 1'b0;
   logic        upd_done = 1'b0;
   logic        rx_ready, en, busy;
   logic [2:0]  fPacketType;
   logic [15:0] fSourceID, fClusterID, fEnergyLeft, fQValue;
   logic [7:0]  drop_count;

   int          n_cmp = 0;
   int          n_err = 0;
   int          en_cnt = 0;
   int          en_before;
   logic [7:0]  exp_drop = 8'd0;

   logic [15:0] t_hdr [5] = '{16'hA000, 16'h8000, 16'h8000, 16'hE000, 16'h2000};
   logic [15:0] t_src [5] = '{16'h0007, 16'hFFFF, 16'h0002, 16'h0002, 16'h0002};
   logic        t_ok  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   pkt_extract #(.WORD_WIDTH(16), .WD_LIMIT(255)) dut (
      .clock(clock), .nrst(nrst), .myNodeID(myNodeID),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_ready(rx_ready),
      .fPacketType(fPacketType), .fSourceID(fSourceID), .fClusterID(fClusterID),
      .fEnergyLeft(fEnergyLeft), .fQValue(fQValue), .en(en), .upd_done(upd_done),
      .busy(busy), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (en === 1'b1) en_cnt++;

   task automatic put(input logic [15:0] d, input logic s);
      @(negedge clock);
      rx_valid = 1'b1; rx_data = d; rx_sop = s;
   endtask

   task automatic gap();
      @(negedge clock);
      rx_valid = 1'b0; rx_sop = 1'b0; rx_data = 16'h0;
   endtask

   // Leaves the bench at the falling edge inside the S_CHECK cycle.
   task automatic send_pkt(input logic [15:0] h, s, c, e, q);
      put(h, 1'b1); put(s, 1'b0); put(c, 1'b0); put(e, 1'b0); put(q, 1'b0);
      gap();
      $display("pkt hdr=%h src=%h clu=%h ene=%h qv=%h", h, s, c, e, q);
   endtask

   task automatic do_reset();
      @(negedge clock);
      nrst = 1'b0; rx_valid = 1'b0; rx_sop = 1'b0;
      @(negedge clock);
      nrst = 1'b1;
      exp_drop = 8'd0;
   endtask

   task automatic test_reset();
      #1 nrst = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", rx_ready); end
      n_cmp++; if (en !== 1'b0) begin n_err++; $display("FAIL reset_en got=%b want=0", en); end
      n_cmp++; if (drop_count !== 8'h00) begin n_err++; $display("FAIL reset_drop got=%h want=00", drop_count); end
      n_cmp++; if ({fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue} !== 67'd0) begin
         n_err++; $display("FAIL reset_fields got=%h want=0", {fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue}); end
      @(negedge clock); @(negedge clock);
      nrst = 1'b1;
      $display("reset released");
   endtask

   task automatic test_valid();
      send_pkt(16'h4000, 16'h0007, 16'h0003, 16'h0F00, 16'h0120);
      n_cmp++; if ({fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue} !== {3'd2, 16'h0007, 16'h0003, 16'h0F00, 16'h0120}) begin
         n_err++; $display("FAIL valid_fields got=%h want=%h", {fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue},
                           {3'd2, 16'h0007, 16'h0003, 16'h0F00, 16'h0120}); end
      n_cmp++; if (en !== 1'b0 || rx_ready !== 1'b0) begin n_err++; $display("FAIL valid_check_en_ready got=%b%b want=00", en, rx_ready); end
      @(negedge clock);
      n_cmp++; if (en !== 1'b1) begin n_err++; $display("FAIL valid_en_T2 got=%b want=1", en); end
      @(negedge clock);
      n_cmp++; if (en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL valid_wait_en_busy got=%b%b want=01", en, busy); end
      repeat (3) @(negedge clock);
      upd_done = 1'b1;
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL valid_release got=%b want=0", busy); end
      n_cmp++; if (fQValue !== 16'h0120 || drop_count !== exp_drop) begin
         n_err++; $display("FAIL valid_hold got=%h/%h want=0120/%h", fQValue, drop_count, exp_drop); end
      n_cmp++; if (en_cnt !== 1) begin n_err++; $display("FAIL valid_en_count got=%0d want=1", en_cnt); end
   endtask

   task automatic test_self_src();
      myNodeID = 16'd7;
      do_reset();
      en_before = en_cnt;
      send_pkt(16'h4000, 16'h0007, 16'h0003, 16'h0F00, 16'h0120);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL self_check_busy got=%b want=1", busy); end
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0 || drop_count !== 8'd1) begin
         n_err++; $display("FAIL self_drop got=%b/%h want=0/01", busy, drop_count); end
      n_cmp++; if (en_cnt !== en_before) begin n_err++; $display("FAIL self_no_en got=%0d want=%0d", en_cnt, en_before); end
      myNodeID = 16'd1;
      do_reset();
   endtask

   task automatic test_abort();
      upd_done = 1'b0;
      put(16'h4000, 1'b1); put(16'h0005, 1'b0); put(16'h6000, 1'b1);
      gap();
      exp_drop = exp_drop + 8'd1;
      n_cmp++; if (drop_count !== exp_drop || busy !== 1'b1 || fPacketType !== 3'd3) begin
         n_err++; $display("FAIL abort_count got=%h/%b/%0d want=%h/1/3", drop_count, busy, fPacketType, exp_drop); end
      put(16'h0009, 1'b0); put(16'h000A, 1'b0); put(16'h000B, 1'b0); put(16'h000C, 1'b0);
      gap();
      n_cmp++; if ({fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue} !== {3'd3, 16'h0009, 16'h000A, 16'h000B, 16'h000C}) begin
         n_err++; $display("FAIL abort_fields got=%h", {fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue}); end
      @(negedge clock);
      n_cmp++; if (en !== 1'b1) begin n_err++; $display("FAIL abort_en got=%b want=1", en); end
      @(negedge clock);
      upd_done = 1'b1;
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0 || drop_count !== exp_drop) begin
         n_err++; $display("FAIL abort_done got=%b/%h want=0/%h", busy, drop_count, exp_drop); end
   endtask

   task automatic test_upd_edge();
      send_pkt(16'h4000, 16'h0007, 16'h0003, 16'h0F00, 16'h0120);
      @(negedge clock);
      repeat (4) @(negedge clock);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL edge_held_high got=%b want=1", busy); end
      upd_done = 1'b0;
      repeat (2) @(negedge clock);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL edge_low got=%b want=1", busy); end
      upd_done = 1'b1;
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL edge_rise got=%b want=0", busy); end
      upd_done = 1'b0;
   endtask

   task automatic test_types();
      for (int i = 0; i < 5; i++) begin
         en_before = en_cnt;
         send_pkt(t_hdr[i], t_src[i], 16'h0011, 16'h0022, 16'h0033);
         @(negedge clock);
         n_cmp++; if (en !== t_ok[i]) begin n_err++; $display("FAIL types_en[%0d] got=%b want=%b", i, en, t_ok[i]); end
         if (t_ok[i]) begin
            @(negedge clock);
            upd_done = 1'b1;
            @(negedge clock);
            upd_done = 1'b0;
         end else begin
            exp_drop = exp_drop + 8'd1;
         end
         n_cmp++; if (busy !== 1'b0 || drop_count !== exp_drop) begin
            n_err++; $display("FAIL types_end[%0d] got=%b/%h want=0/%h", i, busy, drop_count, exp_drop); end
      end
   endtask

   task automatic test_watchdog();
      upd_done = 1'b0;
      send_pkt(16'h4000, 16'h0007, 16'h0003, 16'h0F00, 16'h0120);
      @(negedge clock);
      repeat (255) @(negedge clock);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wd_last_wait got=%b want=1", busy); end
      @(negedge clock);
      exp_drop = exp_drop + 8'd1;
      n_cmp++; if (busy !== 1'b0 || drop_count !== exp_drop) begin
         n_err++; $display("FAIL wd_expire got=%b/%h want=0/%h", busy, drop_count, exp_drop); end
   endtask

   task automatic test_saturate();
      do_reset();
      en_before = en_cnt;
      for (int i = 0; i < 300; i++) send_pkt(16'h0000, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
      @(negedge clock);
      n_cmp++; if (drop_count !== 8'hFF) begin n_err++; $display("FAIL sat_count got=%h want=FF", drop_count); end
      n_cmp++; if (en_cnt !== en_before) begin n_err++; $display("FAIL sat_no_en got=%0d want=%0d", en_cnt, en_before); end
      put(16'h8000, 1'b1); put(16'h0011, 1'b0); put(16'h2000, 1'b1);
      gap();
      n_cmp++; if (drop_count !== 8'hFF || fPacketType !== 3'd1 || busy !== 1'b1) begin
         n_err++; $display("FAIL sat_abort got=%h/%0d/%b want=FF/1/1", drop_count, fPacketType, busy); end
      put(16'h0022, 1'b0);
      gap();
      n_cmp++; if (fSourceID !== 16'h0022 || rx_ready !== 1'b1) begin
         n_err++; $display("FAIL sat_clu got=%h/%b want=0022/1", fSourceID, rx_ready); end
      #2 nrst = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || rx_ready !== 1'b1 || en !== 1'b0 || drop_count !== 8'h00) begin
         n_err++; $display("FAIL async_reset_ctl got=%b%b%b/%h want=010/00", busy, rx_ready, en, drop_count); end
      n_cmp++; if ({fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue} !== 67'd0) begin
         n_err++; $display("FAIL async_reset_fields got=%h want=0", {fPacketType, fSourceID, fClusterID, fEnergyLeft, fQValue}); end
      @(negedge clock);
      nrst = 1'b1;
      put(16'h0123, 1'b0);
      gap();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_nosop got=%b want=0", busy); end
      put(16'h4000, 1'b1);
      gap();
      n_cmp++; if (busy !== 1'b1 || fPacketType !== 3'd2) begin
         n_err++; $display("FAIL post_reset_sop got=%b/%0d want=1/2", busy, fPacketType); end
   endtask

   initial begin
      test_reset();
      test_valid();
      test_self_src();
      test_abort();
      test_upd_edge();
      test_types();
      test_watchdog();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pkt_extract.md
PKT_EXTRACT -- requirements
Module: pkt_extract

Interface
REQ-001 Parameter WORD_WIDTH, default 16, width of every packet word and field.
REQ-002 Parameter WD_LIMIT, default 255, watchdog cycles allowed in S_WAIT.
REQ-003 clock  input  1  single clock, rising-edge.
REQ-004 nrst  input  1  reset, asynchronous and active-low.
REQ-005 myNodeID  input  16  local node ID, static while out of reset.
REQ-006 rx_data  input  16  received packet word.
REQ-007 rx_valid  input  1  rx_data valid this cycle.
REQ-008 rx_sop  input  1  marks the header word (first word of packet).
REQ-009 rx_ready  output  1  word accepted when rx_valid && rx_ready.
REQ-010 fPacketType  output  3  header[15:13] of held packet.
REQ-011 fSourceID, fClusterID, fEnergyLeft, fQValue  output  16 each  held packet fields.
REQ-012 en  output  1  one-cycle start pulse to Q-table update stage.
REQ-013 upd_done  input  1  done level from Q-table update stage.
REQ-014 busy  output  1  high in every state except S_IDLE.
REQ-015 drop_count  output  8  saturating count of discarded packets.

Function
REQ-016 Packet is 5 words in order: header, sourceID, clusterID, energyLeft, QValue; header[12:0] ignored.
REQ-017 States: S_IDLE, S_SRC, S_CLU, S_ENE, S_QV, S_CHECK, S_ISSUE, S_WAIT.
REQ-018 rx_ready = 1 in S_IDLE, S_SRC, S_CLU, S_ENE, S_QV; 0 in S_CHECK, S_ISSUE, S_WAIT.
REQ-019 S_IDLE: accepted word with rx_sop=1 -> capture type, go S_SRC; accepted word with rx_sop=0 -> discard silently, stay.
REQ-020 S_SRC/S_CLU/S_ENE/S_QV: accepted word with rx_sop=0 -> capture field, advance; S_QV advances to S_CHECK.
REQ-021 Accepted word with rx_sop=1 in S_SRC..S_QV -> abort partial packet, drop_count+1, capture as new header, go S_SRC.
REQ-022 No rx_valid -> hold state and captured fields.
REQ-023 S_CHECK (1 cycle): drop if type==0, type>4, fSourceID==myNodeID, or fSourceID==16'hFFFF; drop -> drop_count+1, S_IDLE; else S_ISSUE.
REQ-024 S_ISSUE (1 cycle): en=1, go S_WAIT; en=0 in all other states.
REQ-025 Latency: QValue accepted cycle T -> en high in cycle T+2.
REQ-026 S_WAIT: register upd_done; return S_IDLE on 0->1 transition of upd_done (level already high on entry is not completion).
REQ-027 S_WAIT watchdog counter counts cycles from 0; reaching WD_LIMIT without completion -> drop_count+1, S_IDLE.
REQ-028 Output fields change only on word capture; stable from S_CHECK until leaving S_WAIT.
REQ-029 drop_count saturates at 8'hFF; never wraps.
REQ-030 Simultaneous abort and saturation: count stays 8'hFF, abort still taken.

Reset
REQ-031 nrst low asynchronously forces S_IDLE; en=0, busy=0, rx_ready=1 (combinational from S_IDLE), all fields 0, drop_count 0, watchdog 0, upd_done history register 0.
REQ-032 Reset mid-packet or in S_WAIT discards the packet without counting it; first post-reset word is accepted only with rx_sop=1.

Verification
REQ-033 Valid packet {16'h4000,16'h0007,16'h0003,16'h0F00,16'h0120}, myNodeID=1, words back-to-back -> en pulse cycle T+2, fields 2/7/3/0F00/0120, busy until upd_done 0->1.
REQ-034 Same packet but sourceID=myNodeID=7 -> no en, drop_count 0->1, S_IDLE after S_CHECK.
REQ-035 Header with rx_sop at word 3 of prior packet -> drop_count+1, second packet completes normally with its own fields.
REQ-036 upd_done held high from prior update, then low, then high -> completion only on the rising edge; held-high entry does not release S_WAIT.
REQ-037 upd_done never rises -> after 255 cycles in S_WAIT return S_IDLE, drop_count+1.
REQ-038 300 type-0 packets -> drop_count reads 8'hFF, no en pulses; nrst pulse mid-S_CLU -> all outputs reset values immediately.
